// File: rtl/tinyalu_pkg.sv
// ============================================================================
//  Module   : tinyalu_pkg
//  Purpose  : Opcode type, multiplier latency bounds and latency helper
//             shared by the TinyALU responder and its multiplier pipeline.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package tinyalu_pkg;

    typedef enum logic [2:0] {
        no_op  = 3'b000,
        add_op = 3'b001,
        and_op = 3'b010,
        xor_op = 3'b011,
        mul_op = 3'b100,
        rst_op = 3'b111
    } operation_t;

    localparam int c_MUL_LATENCY_MIN = 2;
    localparam int c_MUL_LATENCY_MAX = 8;

    // Extra edges after acceptance before done; single-cycle ops finish on
    // the acceptance edge itself.
    function automatic int unsigned op_latency(input operation_t opc,
                                               input int unsigned mul_latency);
        return (opc == mul_op) ? (mul_latency - 32'd1) : 32'd0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tinyalu_mul_pipe.sv
// ============================================================================
//  Module   : tinyalu_mul_pipe
//  Purpose  : 8x8 unsigned multiplier with a valid-tagged shift register of
//             MUL_LATENCY-1 stages. Built only when TINYALU_MUL_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

`ifdef TINYALU_MUL_EN
module tinyalu_mul_pipe
    import tinyalu_pkg::*;
#(
    parameter int MUL_LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic [7:0]  i_a,
    input  logic [7:0]  i_b,
    output logic        o_valid,
    output logic [15:0] o_prod
);

    localparam int unsigned c_STAGES = op_latency(mul_op, MUL_LATENCY);

    logic [15:0]         r_prod [c_STAGES];
    logic [c_STAGES-1:0] r_vld;

    // Stage 0 multiplies on the acceptance edge; later stages only delay.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            for (int i = 0; i < c_STAGES; i++) begin
                r_prod[i] <= 16'h0000;
            end
        end else begin
            r_vld[0]  <= i_valid;
            r_prod[0] <= 16'(i_a) * 16'(i_b);
            for (int i = 1; i < c_STAGES; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_prod[i] <= r_prod[i-1];
            end
        end
    end

    assign o_valid = r_vld[c_STAGES-1];
    assign o_prod  = r_prod[c_STAGES-1];

endmodule
`endif

`default_nettype wire

// File: rtl/tinyalu_responder.sv
// ============================================================================
//  Module   : tinyalu_responder
//  Purpose  : TinyALU start/done command responder. Define TINYALU_MUL_EN to
//             build the multiplier; otherwise mul_op is handled as illegal.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tinyalu_responder
    import tinyalu_pkg::*;
#(
    parameter int MUL_LATENCY = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    input  operation_t  op,
    input  logic        start,
    output logic        done,
    output logic [15:0] result,
    output logic        busy
);

`ifdef TINYALU_MUL_EN
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MUL      = 2'd1,
        S_WAIT_LOW = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_LOW = 2'd2
    } state_t;
`endif

    if (MUL_LATENCY < c_MUL_LATENCY_MIN || MUL_LATENCY > c_MUL_LATENCY_MAX) begin : g_bad_mul_latency
        $error("tinyalu_responder: MUL_LATENCY out of range 2..8");
    end

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_done;
    logic        w_done_nxt;
    logic [15:0] r_result;
    logic [15:0] w_result_nxt;

`ifdef TINYALU_MUL_EN
    logic        w_mul_start;
    logic        w_mul_valid;
    logic [15:0] w_mul_prod;

    tinyalu_mul_pipe #(
        .MUL_LATENCY (MUL_LATENCY)
    ) u_mul_pipe (
        .clk     (clk),
        .rst     (reset),
        .i_valid (w_mul_start),
        .i_a     (A),
        .i_b     (B),
        .o_valid (w_mul_valid),
        .o_prod  (w_mul_prod)
    );
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_done   <= 1'b0;
            r_result <= 16'h0000;
        end else begin
            r_state  <= w_state_nxt;
            r_done   <= w_done_nxt;
            r_result <= w_result_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_done_nxt   = 1'b0;
        w_result_nxt = r_result;
`ifdef TINYALU_MUL_EN
        w_mul_start  = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        no_op: begin
                        end
                        rst_op: begin
                            w_result_nxt = 16'h0000;
                        end
                        add_op: begin
                            w_result_nxt = 16'(A) + 16'(B);
                            w_done_nxt   = 1'b1;
                            w_state_nxt  = S_WAIT_LOW;
                        end
                        and_op: begin
                            w_result_nxt = {8'h00, A & B};
                            w_done_nxt   = 1'b1;
                            w_state_nxt  = S_WAIT_LOW;
                        end
                        xor_op: begin
                            w_result_nxt = {8'h00, A ^ B};
                            w_done_nxt   = 1'b1;
                            w_state_nxt  = S_WAIT_LOW;
                        end
`ifdef TINYALU_MUL_EN
                        mul_op: begin
                            w_mul_start = 1'b1;
                            w_state_nxt = S_MUL;
                        end
`endif
                        // Illegal codes (and mul_op without a multiplier)
                        // complete immediately with a zero result.
                        default: begin
                            w_result_nxt = 16'h0000;
                            w_done_nxt   = 1'b1;
                            w_state_nxt  = S_WAIT_LOW;
                        end
                    endcase
                end
            end
`ifdef TINYALU_MUL_EN
            // start is deliberately ignored here so a dropped request still
            // completes.
            S_MUL: begin
                if (w_mul_valid) begin
                    w_result_nxt = w_mul_prod;
                    w_done_nxt   = 1'b1;
                    w_state_nxt  = S_WAIT_LOW;
                end
            end
`endif
            S_WAIT_LOW: begin
                if (!start) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign done   = r_done;
    assign result = r_result;
    assign busy   = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_tinyalu_responder.sv
// ============================================================================
//  Module   : tb_tinyalu_responder
//  Purpose  : Directed and randomized self-checking bench for the TinyALU
//             responder, valid with or without TINYALU_MUL_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tinyalu_responder;
    import tinyalu_pkg::*;

    localparam int LAT = 3;
`ifdef TINYALU_MUL_EN
    localparam bit c_MUL_EN = 1'b1;
`else
    localparam bit c_MUL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  a_in = 8'h00;
    logic [7:0]  b_in = 8'h00;
    operation_t  op_in = no_op;
    logic        start = 1'b0;
    logic        done;
    logic [15:0] result;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int done_count = 0;
    logic [15:0] exp_result = 16'h0000;

    tinyalu_responder #(
        .MUL_LATENCY (LAT)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .A      (a_in),
        .B      (b_in),
        .op     (op_in),
        .start  (start),
        .done   (done),
        .result (result),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_count++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference ALU built straight from the opcode table.
    function automatic logic [15:0] ref_alu(input logic [2:0] opc,
                                            input logic [7:0] a, input logic [7:0] b);
        int ia = int'(a);
        int ib = int'(b);
        case (opc)
            3'b001:  return 16'(ia + ib);
            3'b010:  return 16'(ia & ib);
            3'b011:  return 16'(ia ^ ib);
            3'b100:  return c_MUL_EN ? 16'(ia * ib) : 16'h0000;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One BFM-style command: raise start, wait for done, hold, drop start.
    task automatic do_cmd(input logic [2:0] opc, input logic [7:0] a,
                          input logic [7:0] b, input int hold);
        int lat;
        int n;
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        op_in = operation_t'(opc);
        start = 1'b1;
        if (opc == 3'b000 || opc == 3'b111) begin
            @(posedge clk); #1;
            if (opc == 3'b111) exp_result = 16'h0000;
            chk("nocalc_done", 32'(done), 32'd0);
            chk("nocalc_result", 32'(result), 32'(exp_result));
            chk("nocalc_busy", 32'(busy), 32'd0);
            @(negedge clk);
            start = 1'b0;
        end else begin
            exp_result = ref_alu(opc, a, b);
            lat = (opc == 3'b100 && c_MUL_EN) ? LAT - 1 : 0;
            n = 0;
            @(posedge clk); #1;
            if (done !== 1'b1) begin
                a_in  = 8'($urandom);
                b_in  = 8'($urandom);
                op_in = operation_t'(3'($urandom));
            end
            while (done !== 1'b1 && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            chk("latency", 32'(n), 32'(lat));
            chk("result", 32'(result), 32'(exp_result));
            chk("busy_at_done", 32'(busy), 32'd1);
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                chk("hold_done_low", 32'(done), 32'd0);
                chk("hold_busy", 32'(busy), 32'd1);
            end
            @(negedge clk);
            start = 1'b0;
            @(posedge clk); #1;
            chk("done_cleared", 32'(done), 32'd0);
            chk("idle_after_drop", 32'(busy), 32'd0);
            chk("result_held", 32'(result), 32'(exp_result));
        end
    endtask

    initial begin
        int base;
        int r;
        logic [2:0] ropc;

        #1;
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_result", 32'(result), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        do_cmd(3'b001, 8'hFF, 8'h01, 0);
        chk("add_ff_01", 32'(result), 32'h0100);

        do_cmd(3'b100, 8'hFF, 8'hFF, 0);
        chk("mul_ff_ff", 32'(result), c_MUL_EN ? 32'hFE01 : 32'h0000);

        base = done_count;
        do_cmd(3'b010, 8'hF0, 8'h3C, 0);
        chk("and_f0_3c", 32'(result), 32'h0030);
        do_cmd(3'b011, 8'hF0, 8'h3C, 0);
        chk("xor_f0_3c", 32'(result), 32'h00CC);
        chk("b2b_done_pulses", 32'(done_count - base), 32'd2);

        base = done_count;
        do_cmd(3'b000, 8'h12, 8'h34, 0);
        chk("noop_no_done", 32'(done_count - base), 32'd0);
        chk("noop_result_kept", 32'(result), 32'h00CC);
        do_cmd(3'b101, 8'h12, 8'h34, 0);
        chk("illegal_result", 32'(result), 32'h0000);
        chk("illegal_one_done", 32'(done_count - base), 32'd1);

        // Reset asserted one edge into a multiply.
        do_cmd(3'b001, 8'h40, 8'h02, 0);
        base = done_count;
        @(negedge clk);
        a_in  = 8'h11;
        b_in  = 8'h22;
        op_in = mul_op;
        start = 1'b1;
        @(posedge clk); #1;
        chk("mul_pre_reset_done", 32'(done), c_MUL_EN ? 32'd0 : 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("async_reset_result", 32'(result), 32'd0);
        chk("async_reset_done", 32'(done), 32'd0);
        chk("async_reset_busy", 32'(busy), 32'd0);
        start = 1'b0;
        base = done_count;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("reset_discard_done", 32'(done_count - base), 32'd0);
        chk("reset_discard_result", 32'(result), 32'd0);
        exp_result = 16'h0000;
        do_cmd(3'b001, 8'd2, 8'd3, 0);
        chk("add_after_reset", 32'(result), 32'h0005);

        base = done_count;
        do_cmd(3'b001, 8'h80, 8'h80, 5);
        chk("hold_one_done", 32'(done_count - base), 32'd1);

        do_cmd(3'b111, 8'h00, 8'h00, 0);
        chk("rst_op_clear", 32'(result), 32'd0);

        for (int i = 0; i < 40; i++) begin
            ropc = 3'($urandom);
            r = int'($urandom_range(0, 2));
            base = done_count;
            do_cmd(ropc, 8'($urandom), 8'($urandom), r);
            chk("rand_done_count", 32'(done_count - base),
                (ropc == 3'b000 || ropc == 3'b111) ? 32'd0 : 32'd1);
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tinyalu_responder.md
# tinyalu_responder

Synthesizable responder for the TinyALU start/done command protocol. It samples `A`, `B` and `op` when `start` is raised and returns a 16-bit `result` with a one-cycle `done` pulse. It sits on the DUT side of `tinyalu_bfm`, is driven directly by the BFM's `send_op` task, and serves as the reference ALU for the class-based testbench.

## Interface
- `MUL_LATENCY`, default 3: edges from acceptance to result for `mul_op`; legal range 2..8.
- `clk`  in  1  clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset. The bench connects `~reset_n` here.
- `A`  in  8  unsigned operand A.
- `B`  in  8  unsigned operand B.
- `op`  in  3  opcode, typed `operation_t` from `tinyalu_pkg`.
- `start`  in  1  command request, held high by the initiator until it sees `done`.
- `done`  out  1  one-cycle completion pulse.
- `result`  out  16  registered result, held between commands.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- Opcodes:
  - `no_op` = 000
  - `add_op` = 001
  - `and_op` = 010
  - `xor_op` = 011
  - `mul_op` = 100
  - `rst_op` = 111
  - 101 and 110 are illegal.
- Arithmetic, all zero-extended to 16 bits:
  - add: `A+B` (carry lands in bit 8)
  - and: `{8'h00, A&B}`
  - xor: `{8'h00, A^B}`
  - mul: `A*B` (full 16-bit product)
- FSM states: IDLE, MUL, WAIT_LOW.
- Acceptance: a command is accepted on a rising edge where the state is IDLE and `start`=1. `A`, `B` and `op` are captured on that edge. Later changes to them are ignored.
- IDLE transitions:
  - add/and/xor/illegal: on the acceptance edge, `result` is updated and `done` is set. Next state is WAIT_LOW.
  - mul: operands enter the multiplier pipeline. Next state is MUL.
  - `no_op`: nothing is computed, no `done`, `result` unchanged. State stays IDLE. The initiator drops `start` without waiting.
  - `rst_op` with `start`=1: synchronous clear. `result` is set to 0, no `done`. State stays IDLE.
- Illegal opcodes: `result`=16'h0000 and `done` pulses, as for a single-cycle op.
- MUL: counts down MUL_LATENCY-1 edges. On the last edge it loads the product into `result`, sets `done`, and goes to WAIT_LOW.
- WAIT_LOW: `done` is cleared on the first edge in this state. The FSM returns to IDLE on the first edge where `start`=0. No command can be accepted on that edge, so `start` must be low for at least one edge between commands.
- If `start` drops during MUL (protocol violation), the multiply still completes and `done` still pulses.

## Timing
- Reset values: `done`=0, `result`=16'h0000, `busy`=0, state IDLE, pipeline cleared.
- Latency, with acceptance at edge k:
  - add/and/xor/illegal: `done` and `result` are valid from edge k.
  - mul: valid from edge k+MUL_LATENCY-1 (edge k+2 at the default).
- `done` is high for exactly one clock period, then low until the next completion.
- `result` is stable from the `done` edge until the next completion, the next `rst_op`, or reset.
- Reset asserted mid-command, including during MUL: all outputs go to their reset values immediately, and the in-flight result is discarded with no `done`.
- Back-to-back commands under BFM timing complete with no lost or duplicated `done` pulses.

## Configuration
- `TINYALU_MUL_EN` defined: the multiplier pipeline is instantiated and `mul_op` behaves as described above.
- `TINYALU_MUL_EN` undefined:
  - No multiplier, no MUL state, MUL_LATENCY unused.
  - `mul_op` is treated as illegal: `result`=0 with a single-cycle `done`.

## Structure
- `tinyalu_pkg` holds:
  - `operation_t`;
  - an opcode-to-latency helper function;
  - the MUL_LATENCY bounds as constants.
- The FSM state enum stays local to the module.
- Sub-module `tinyalu_mul_pipe`, parameterized by MUL_LATENCY: 8x8 unsigned multiply with a valid-in/valid-out shift register. It is compiled only under `TINYALU_MUL_EN`.

## Test plan
- Reset, then `add_op` A=8'hFF B=8'h01 -> `result`=16'h0100, one `done` pulse, `busy` low after `start` drops.
- `mul_op` A=8'hFF B=8'hFF with MUL_LATENCY=3 -> `done` two edges after acceptance, `result`=16'hFE01. Without the macro -> `result`=0 with single-cycle `done`.
- `and_op` 8'hF0/8'h3C -> 16'h0030, then `xor_op` 8'hF0/8'h3C -> 16'h00CC, issued back-to-back through `send_op` -> exactly two `done` pulses.
- `no_op`, then opcode 3'b101 -> `no_op` gives no `done` and leaves `result` unchanged; 3'b101 gives `result`=0 with `done`.
- Assert `reset` one edge into a `mul_op` -> `done` never pulses, `result`=0, a following `add_op` 2+3 returns 16'h0005.
- Hold `start` high for 5 cycles after `done` on an `add_op` -> only one `done`, FSM stays in WAIT_LOW and returns to IDLE only after `start` falls.
